// File: rtl/prefetch_queue.sv
// Bus interface unit: prefetches instruction bytes from CS:IP into a small byte queue
// and shares the single byte-wide memory port with core data accesses (data wins).
module prefetch_queue #(
    parameter int unsigned DEPTH    = 6,
    parameter logic [15:0] RESET_CS = 16'hF000,
    parameter logic [15:0] RESET_IP = 16'hFFF0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [19:0] mem_address,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_out,
    input  logic [7:0]  mem_in,
    input  logic        mem_ready,
    input  logic        flush,
    input  logic [15:0] new_cs,
    input  logic [15:0] new_ip,
    output logic        q_valid,
    output logic [7:0]  q_data,
    output logic [15:0] q_ip,
    input  logic        q_pop,
    input  logic        d_req,
    input  logic [19:0] d_address,
    input  logic        d_we,
    input  logic [7:0]  d_out,
    output logic [7:0]  d_in,
    output logic        d_ack
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA,
        DISCARD
    } state_t;

    state_t        state;
    logic [7:0]    entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   fetch_cs;
    logic [15:0]   fetch_ip;
    logic [15:0]   head_ip;
    logic [19:0]   fetch_addr;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        fetch_addr = {fetch_cs, 4'h0} + {4'h0, fetch_ip};
        push       = (state == FETCH) && mem_ready && !flush;
        pop        = q_pop && (count != '0) && !flush;
        q_valid    = (count != '0);
        q_data     = (count != '0) ? entries[rd_ptr] : '0;
        q_ip       = head_ip;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entries[wr_ptr] <= mem_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_address <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_out     <= '0;
            d_in        <= '0;
            d_ack       <= 1'b0;
        end else begin
            d_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    // d_req is still high in the d_ack cycle; that access is already done
                    if (d_req && !d_ack) begin
                        state       <= DATA;
                        mem_address <= d_address;
                        mem_we      <= d_we;
                        mem_out     <= d_out;
                        mem_req     <= 1'b1;
                    end else if ((count < FULL_CNT) && !flush) begin
                        state       <= FETCH;
                        mem_address <= fetch_addr;
                        mem_we      <= 1'b0;
                        mem_req     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        state <= DISCARD;
                    end
                end
                DATA: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ack   <= 1'b1;
                        if (!mem_we) begin
                            d_in <= mem_in;
                        end
                        state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_cs <= RESET_CS;
            fetch_ip <= RESET_IP;
            head_ip  <= RESET_IP;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_cs <= new_cs;
            fetch_ip <= new_ip;
            head_ip  <= new_ip;
        end else begin
            if (push) begin
                wr_ptr   <= ptr_inc(wr_ptr);
                fetch_ip <= fetch_ip + 16'd1;
            end
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                head_ip <= head_ip + 16'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: transaction-level queue/memory model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prefetch_queue;
    localparam int DEPTH = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] mem_address;
    logic        mem_req, mem_we;
    logic [7:0]  mem_out;
    logic [7:0]  mem_in = '0;
    logic        mem_ready = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] new_cs = '0, new_ip = '0;
    logic        q_valid;
    logic [7:0]  q_data;
    logic [15:0] q_ip;
    logic        q_pop = 1'b0;
    logic        d_req = 1'b0;
    logic [19:0] d_address = '0;
    logic        d_we = 1'b0;
    logic [7:0]  d_out = '0;
    logic [7:0]  d_in;
    logic        d_ack;

    prefetch_queue #(.DEPTH(DEPTH), .RESET_CS(16'hF000), .RESET_IP(16'hFFF0)) dut (
        .clock(clock), .reset(reset),
        .mem_address(mem_address), .mem_req(mem_req), .mem_we(mem_we), .mem_out(mem_out),
        .mem_in(mem_in), .mem_ready(mem_ready),
        .flush(flush), .new_cs(new_cs), .new_ip(new_ip),
        .q_valid(q_valid), .q_data(q_data), .q_ip(q_ip), .q_pop(q_pop),
        .d_req(d_req), .d_address(d_address), .d_we(d_we), .d_out(d_out),
        .d_in(d_in), .d_ack(d_ack)
    );

    always #5 clock = ~clock;

    int ncmp = 0;
    int nerr = 0;

    logic [7:0]  wmem [logic [19:0]];
    logic [7:0]  mq [$];
    logic [15:0] m_cs, m_ip, m_qip;
    logic [7:0]  m_din;
    logic        m_dack;
    logic        busy, cur_data, cur_we, discard;
    logic [19:0] cur_addr;
    logic [7:0]  cur_out;
    int          wait_cnt;
    logic        prev_req, prev_ready, prev_want, prev_flush;
    int          prev_size;
    logic [19:0] fetch_addrs [$];
    logic        started_fetch;
    logic        dstart_we;
    logic [7:0]  dstart_out;

    int          lat_mode = 0;
    logic        rnd = 1'b0;
    int          pop_pct = 50;
    logic        st_pop = 1'b0, st_flush = 1'b0, st_dreq = 1'b0, st_dwe = 1'b0;
    logic [15:0] st_cs = '0, st_ip = '0;
    logic [19:0] st_daddr = '0;
    logic [7:0]  st_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] memread(input logic [19:0] a);
        if (wmem.exists(a)) return wmem[a];
        if (a[19:4] == 16'hFFFF) return {4'h0, a[3:0]};
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]};
    endfunction

    function automatic logic [19:0] fa(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'h0} + {4'h0, ip};
    endfunction

    task automatic model_init();
        mq.delete();
        m_cs = 16'hF000; m_ip = 16'hFFF0; m_qip = 16'hFFF0;
        m_din = '0; m_dack = 1'b0; busy = 1'b0; discard = 1'b0;
        prev_req = 1'b0; prev_ready = 1'b0; prev_want = 1'b0; prev_flush = 1'b0; prev_size = 0;
    endtask

    // Compare DUT outputs (stable since the last rising edge) with the model.
    task automatic step_check();
        logic exp_req;
        started_fetch = 1'b0;
        exp_req = prev_req ? !prev_ready : (prev_want || (prev_size < DEPTH && !prev_flush));
        chk("mem_req", mem_req, exp_req);
        chk("q_valid", q_valid, mq.size() != 0);
        if (mq.size() != 0) chk("q_data", q_data, mq[0]);
        chk("q_ip", q_ip, m_qip);
        chk("d_ack", d_ack, m_dack);
        chk("d_in", d_in, m_din);
        if (mem_req && exp_req) begin
            if (!prev_req) begin
                busy = 1'b1; cur_data = prev_want; discard = 1'b0;
                cur_addr = mem_address; cur_we = mem_we; cur_out = mem_out;
                wait_cnt = (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
                if (cur_data) begin
                    chk("data addr", mem_address, d_address);
                    chk("data we", mem_we, d_we);
                    if (d_we) chk("data wdata", mem_out, d_out);
                    dstart_we = mem_we; dstart_out = mem_out;
                end else begin
                    chk("fetch addr", mem_address, fa(m_cs, m_ip));
                    chk("fetch we", mem_we, 0);
                    fetch_addrs.push_back(mem_address);
                    started_fetch = 1'b1;
                end
            end else begin
                chk("req hold", {mem_address, mem_we, mem_out}, {cur_addr, cur_we, cur_out});
            end
        end
    endtask

    // Drive inputs for this cycle, then advance the model across the coming rising edge.
    task automatic step_drive_update();
        int   sz;
        logic comp;
        if (d_ack) d_req = 1'b0;
        if (st_dreq && !d_req && !d_ack) begin
            d_req = 1'b1; d_address = st_daddr; d_we = st_dwe; d_out = st_dout; st_dreq = 1'b0;
        end
        if (rnd) begin
            q_pop  = ($urandom_range(0, 99) < pop_pct);
            flush  = ($urandom_range(0, 31) == 0);
            new_cs = 16'($urandom);
            new_ip = 16'($urandom);
            if (!d_req && !d_ack && $urandom_range(0, 15) == 0) begin
                d_req = 1'b1; d_address = 20'($urandom); d_we = 1'($urandom); d_out = 8'($urandom);
            end
        end else begin
            q_pop = st_pop; flush = st_flush; new_cs = st_cs; new_ip = st_ip; st_flush = 1'b0;
        end
        comp = 1'b0;
        if (busy && mem_req) begin
            if (wait_cnt == 0) comp = 1'b1;
            else wait_cnt--;
        end
        mem_ready = comp;
        mem_in = (comp && !(cur_data && cur_we)) ? memread(cur_addr) : 8'($urandom);

        sz = mq.size();
        prev_want = d_req && !d_ack;
        prev_req = mem_req; prev_ready = comp; prev_flush = flush; prev_size = sz;
        m_dack = 1'b0;
        if (!flush && q_pop && sz != 0) begin
            mq.delete(0);
            m_qip++;
        end
        if (comp) begin
            busy = 1'b0;
            if (cur_data) begin
                m_dack = 1'b1;
                if (cur_we) wmem[cur_addr] = cur_out;
                else m_din = mem_in;
            end else if (!discard && !flush) begin
                mq.push_back(mem_in);
                m_ip++;
            end
        end
        if (flush) begin
            mq.delete();
            m_cs = new_cs; m_ip = new_ip; m_qip = new_ip;
            if (busy && !cur_data) discard = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        step_check();
        step_drive_update();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; d_req = 1'b0; q_pop = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        st_dreq = 1'b0; st_flush = 1'b0;
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst q_valid", q_valid, 0);
        chk("rst q_data", q_data, 0);
        chk("rst q_ip", q_ip, 16'hFFF0);
        chk("rst d_ack", d_ack, 0);
        chk("rst d_in", d_in, 0);
        chk("rst mem_address", mem_address, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_out", mem_out, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_init();
        step_drive_update();
    endtask

    task automatic wait_fetch_start(input string name);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = started_fetch;
        end
        chk({name, " fetch start timeout"}, found, 1);
    endtask

    task automatic wait_fetches(input string name, input int target);
        for (int i = 0; i < 40 && fetch_addrs.size() < target; i++) cycle();
        chk({name, " fetch count timeout"}, fetch_addrs.size() >= target, 1);
    endtask

    task automatic data_access(input logic [19:0] a, input logic we, input logic [7:0] wd);
        logic found = 1'b0;
        st_daddr = a; st_dwe = we; st_dout = wd; st_dreq = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = d_ack;
        end
        chk("d_ack timeout", found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();

        // Fill from reset with zero-wait memory, no pops.
        lat_mode = 0; st_pop = 1'b0;
        repeat (30) cycle();
        chk("fill fetch count", fetch_addrs.size(), 6);
        chk("fill first addr", fetch_addrs[0], 20'hFFFF0);
        chk("fill sixth addr", fetch_addrs[5], 20'hFFFF5);
        chk("fill head data", q_data, 8'h00);
        chk("fill head ip", q_ip, 16'hFFF0);

        // Pop six, then keep popping until the queue runs dry.
        st_pop = 1'b1;
        repeat (6) cycle();
        st_pop = 1'b0;
        cycle();
        chk("pop head ip", q_ip, 16'hFFF6);
        chk("pop head data", q_data, 8'h06);
        st_pop = 1'b1;
        repeat (40) cycle();

        // Flush during a slow fetch.
        lat_mode = 3;
        wait_fetch_start("flush");
        st_pop = 1'b0; st_flush = 1'b1; st_cs = 16'h1234; st_ip = 16'h0010;
        cycle();
        cycle();
        chk("flush q_valid", q_valid, 0);
        chk("flush q_ip", q_ip, 16'h0010);
        lat_mode = 0;
        n = fetch_addrs.size();
        wait_fetches("flush", n + 1);
        chk("flush next addr", fetch_addrs[n], 20'h12350);
        repeat (3) cycle();
        chk("flush head data", q_data, 8'h62);
        chk("flush head ip", q_ip, 16'h0010);
        chk("flush head valid", q_valid, 1);

        // Data read, write, read-back.
        data_access(20'h00400, 1'b0, 8'h00);
        chk("data read d_in", d_in, 8'h04);
        data_access(20'h00401, 1'b1, 8'hA5);
        chk("data write we", dstart_we, 1);
        chk("data write out", dstart_out, 8'hA5);
        data_access(20'h00401, 1'b0, 8'h00);
        chk("data readback d_in", d_in, 8'hA5);

        // Segment wrap without CS carry.
        st_flush = 1'b1; st_cs = 16'hFFFF; st_ip = 16'hFFFF;
        cycle();
        n = fetch_addrs.size();
        wait_fetches("wrap", n + 2);
        chk("wrap addr0", fetch_addrs[n], 20'h0FFEF);
        chk("wrap addr1", fetch_addrs[n + 1], 20'hFFFF0);

        // Asynchronous reset in the middle of a fetch.
        lat_mode = 5; st_pop = 1'b1;
        wait_fetch_start("async");
        st_pop = 1'b0;
        cycle();
        #2 reset = 1'b1;
        #1;
        chk("async mem_req", mem_req, 0);
        chk("async q_valid", q_valid, 0);
        chk("async q_ip", q_ip, 16'hFFF0);
        do_reset();
        lat_mode = 0;
        n = fetch_addrs.size();
        wait_fetches("async", n + 1);
        chk("async restart addr", fetch_addrs[n], 20'hFFFF0);

        // Randomized traffic.
        lat_mode = -1; rnd = 1'b1; pop_pct = 50;
        repeat (1000) cycle();
        pop_pct = 10;
        repeat (800) cycle();
        rnd = 1'b0; st_pop = 1'b0; st_flush = 1'b0;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nerr);
        $finish;
    end
endmodule
